// File: rtl/parse_act_sched_pkg.sv
// Shared parser definitions: FSM encoding, parse action field layout,
// container type codes and bank geometry.
package parse_act_sched_pkg;

   localparam int CONT_NUM = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_OUT   = 2'd3;

   localparam int VALID_BIT = 0;
   localparam int SEQ_LSB   = 1;
   localparam int SEQ_MSB   = 3;
   localparam int TYPE_LSB  = 4;
   localparam int TYPE_MSB  = 5;
   localparam int OFF_LSB   = 6;
   localparam int OFF_MSB   = 12;

   localparam logic [1:0] TYPE_NONE = 2'b00;
   localparam logic [1:0] TYPE_2B   = 2'b01;
   localparam logic [1:0] TYPE_4B   = 2'b10;
   localparam logic [1:0] TYPE_6B   = 2'b11;

endpackage

// File: rtl/parse_act_sched_sub_parser.sv
// sub_parser: extracts up to VAL_OUT_LEN bits at a byte offset of the
// header and registers the value with its target slot and container type.
module sub_parser #(
   parameter int PKTS_HDR_LEN  = 1024,
   parameter int PARSE_ACT_LEN = 16,
   parameter int VAL_OUT_LEN   = 48
) (
   input  logic                     clk,
   input  logic                     aresetn,
   input  logic [PKTS_HDR_LEN-1:0]  pkts_hdr,
   input  logic                     parse_act_valid,
   input  logic [PARSE_ACT_LEN-1:0] parse_act,
   output logic                     val_out_valid,
   output logic [1:0]               val_out_type,
   output logic [2:0]               val_out_seq,
   output logic [VAL_OUT_LEN-1:0]   val_out
);
   import parse_act_sched_pkg::*;

   logic [6:0]              off;
   logic [PKTS_HDR_LEN-1:0] shifted;
   logic                    unused_bits;

   assign off     = parse_act[OFF_MSB:OFF_LSB];
   assign shifted = pkts_hdr >> {off, 3'b000};

   assign unused_bits = ^{parse_act[PARSE_ACT_LEN-1:OFF_MSB+1],
                          shifted[PKTS_HDR_LEN-1:VAL_OUT_LEN]};

   // Register the extracted value; invalid actions come out as type none
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         val_out_valid <= 1'b0;
         val_out_type  <= TYPE_NONE;
         val_out_seq   <= 3'd0;
         val_out       <= '0;
      end else begin
         val_out_valid <= parse_act_valid;
         val_out_seq   <= parse_act[SEQ_MSB:SEQ_LSB];
         val_out_type  <= parse_act[VALID_BIT] ?
                          parse_act[TYPE_MSB:TYPE_LSB] : TYPE_NONE;
         val_out       <= shifted[VAL_OUT_LEN-1:0];
      end
   end

endmodule

// File: rtl/parse_act_sched.sv
// Parse action sequencer: walks a packet's action list through sub_parser
// into PHV banks. Optional PARSE_ACT_EARLY_TERM_EN stops at the first invalid action.
module parse_act_sched #(
   parameter int PKTS_HDR_LEN  = 1024,
   parameter int PARSE_ACT_LEN = 16,
   parameter int NUM_ACTS      = 10,
   parameter int VAL_OUT_LEN   = 48,
   parameter int CONT_NUM      = 8
) (
   input  logic                              clk,
   input  logic                              aresetn,
   input  logic                              s_valid,
   output logic                              s_ready,
   input  logic [PKTS_HDR_LEN-1:0]           s_pkts_hdr,
   input  logic [NUM_ACTS*PARSE_ACT_LEN-1:0] s_parse_acts,
   output logic                              m_valid,
   input  logic                              m_ready,
   output logic [CONT_NUM*16-1:0]            m_phv_2b,
   output logic [CONT_NUM*32-1:0]            m_phv_4b,
   output logic [CONT_NUM*48-1:0]            m_phv_6b
);
   import parse_act_sched_pkg::*;

   localparam int IDX_W = (NUM_ACTS > 1) ? $clog2(NUM_ACTS) : 1;

   logic [1:0]                        state;
   logic [1:0]                        state_nxt;
   logic [IDX_W-1:0]                  idx;
   logic [PKTS_HDR_LEN-1:0]           hdr_q;
   logic [NUM_ACTS*PARSE_ACT_LEN-1:0] acts_q;
   logic                              accept;
   logic                              first_issue;
   logic                              last_issue;
   logic                              parse_act_valid;
   logic [PARSE_ACT_LEN-1:0]          parse_act;
   logic                              val_out_valid;
   logic [1:0]                        val_out_type;
   logic [2:0]                        val_out_seq;
   logic [VAL_OUT_LEN-1:0]            val_out;

   assign s_ready = aresetn && (state == ST_IDLE);
   assign m_valid = (state == ST_OUT);
   assign accept  = s_valid && s_ready;

   assign parse_act_valid = (state == ST_ISSUE);
   assign parse_act = acts_q[idx*PARSE_ACT_LEN +: PARSE_ACT_LEN];

`ifdef PARSE_ACT_EARLY_TERM_EN
   logic [NUM_ACTS:0] vld_ext;
   logic [IDX_W:0]    idx_p1;

   for (genvar i = 0; i < NUM_ACTS; i++) begin : g_vld
      assign vld_ext[i] = acts_q[i*PARSE_ACT_LEN+VALID_BIT];
   end
   assign vld_ext[NUM_ACTS] = 1'b0;
   assign idx_p1 = {1'b0, idx} + 1'b1;

   assign first_issue = s_parse_acts[VALID_BIT];
   assign last_issue  = (idx == IDX_W'(NUM_ACTS-1)) ||
                        !vld_ext[idx_p1];
`else
   assign first_issue = 1'b1;
   assign last_issue  = (idx == IDX_W'(NUM_ACTS-1));
`endif

   // Next-state selection for the issue sequence
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (s_valid)
               state_nxt = first_issue ? ST_ISSUE : ST_DRAIN;
         end
         ST_ISSUE: begin
            if (last_issue)
               state_nxt = ST_DRAIN;
         end
         ST_DRAIN: state_nxt = ST_OUT;
         ST_OUT: begin
            if (m_ready)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State, action index and captured packet registers
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state <= ST_IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            hdr_q  <= s_pkts_hdr;
            acts_q <= s_parse_acts;
            idx    <= '0;
         end else if (state == ST_ISSUE) begin
            idx <= idx + 1'b1;
         end
      end
   end

   sub_parser #(
      .PKTS_HDR_LEN  (PKTS_HDR_LEN),
      .PARSE_ACT_LEN (PARSE_ACT_LEN),
      .VAL_OUT_LEN   (VAL_OUT_LEN)
   ) u_sub_parser (
      .clk             (clk),
      .aresetn         (aresetn),
      .pkts_hdr        (hdr_q),
      .parse_act_valid (parse_act_valid),
      .parse_act       (parse_act),
      .val_out_valid   (val_out_valid),
      .val_out_type    (val_out_type),
      .val_out_seq     (val_out_seq),
      .val_out         (val_out)
   );

   // Bank write-back; cleared on accept so each PHV holds only its own values
   always_ff @(posedge clk) begin
      if (!aresetn || accept) begin
         m_phv_2b <= '0;
         m_phv_4b <= '0;
         m_phv_6b <= '0;
      end else if (val_out_valid) begin
         case (val_out_type)
            TYPE_2B: m_phv_2b[{val_out_seq, 4'b0000} +: 16] <= val_out[15:0];
            TYPE_4B: m_phv_4b[{val_out_seq, 5'b00000} +: 32] <= val_out[31:0];
            TYPE_6B: m_phv_6b[int'(val_out_seq)*48 +: 48] <= val_out[47:0];
            default: ;
         endcase
      end
   end

endmodule
